// File: rtl/ysyx_25020037_hazard_sched.sv
// Issue scheduler between IDU and EXU: tracks in-flight GPR writers and outstanding
// loads, and holds issue on load-use, window-full or per-register counter saturation.
module ysyx_25020037_hazard_sched #(
    parameter int NREG         = 16,
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    output logic       issue_ready,
    input  logic [3:0] issue_rs1,
    input  logic       issue_rs1_used,
    input  logic [3:0] issue_rs2,
    input  logic       issue_rs2_used,
    input  logic [3:0] issue_rd,
    input  logic       issue_we,
    input  logic       issue_is_load,
    input  logic       exu_ready,
    input  logic       flush,
    input  logic       load_done_valid,
    input  logic [3:0] load_done_rd,
    input  logic       retire_valid,
    input  logic [3:0] retire_rd,
    output logic [2:0] inflight_cnt,
    output logic       stall_load,
    output logic       stall_full,
    output logic       sb_err
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] wcnt     [NREG];
    logic [CNT_W-1:0] lcnt     [NREG];
    logic [CNT_W-1:0] wcnt_nxt [NREG];
    logic [CNT_W-1:0] lcnt_nxt [NREG];
    logic [2:0]       inflight;
    logic [2:0]       inflight_nxt;
    logic             sb_err_nxt;

    logic fire_w;
    logic fire_l;
    logic ret;
    logic ld;
    logic hazard_load;
    logic hazard_full;

    always_comb begin
        hazard_load = (issue_rs1_used && issue_rs1 != 4'd0 && lcnt[issue_rs1] != '0) ||
                      (issue_rs2_used && issue_rs2 != 4'd0 && lcnt[issue_rs2] != '0);
        // A retire in the same cycle frees a window slot but never a counter slot.
        hazard_full = (inflight == 3'(MAX_INFLIGHT) && !retire_valid) ||
                      (issue_we && issue_rd != 4'd0 && wcnt[issue_rd] == CNT_MAX) ||
                      (issue_is_load && issue_rd != 4'd0 && lcnt[issue_rd] == CNT_MAX);
        stall_load  = !rst && hazard_load;
        stall_full  = !rst && hazard_full;
        issue_ready = !rst && exu_ready && !flush && !hazard_load && !hazard_full;
    end

    assign fire_w       = issue_valid && issue_ready && issue_we && issue_rd != 4'd0;
    assign fire_l       = fire_w && issue_is_load;
    assign ret          = retire_valid && retire_rd != 4'd0;
    assign ld           = load_done_valid && load_done_rd != 4'd0;
    assign inflight_cnt = inflight;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            wcnt_nxt[r] = wcnt[r];
            lcnt_nxt[r] = lcnt[r];
        end
        for (int r = 1; r < NREG; r++) begin
            if (fire_w && issue_rd == 4'(r) && !(ret && retire_rd == 4'(r)))
                wcnt_nxt[r] = wcnt[r] + CNT_W'(1);
            else if (!(fire_w && issue_rd == 4'(r)) && ret && retire_rd == 4'(r) && wcnt[r] != '0)
                wcnt_nxt[r] = wcnt[r] - CNT_W'(1);
            if (fire_l && issue_rd == 4'(r) && !(ld && load_done_rd == 4'(r)))
                lcnt_nxt[r] = lcnt[r] + CNT_W'(1);
            else if (!(fire_l && issue_rd == 4'(r)) && ld && load_done_rd == 4'(r) && lcnt[r] != '0)
                lcnt_nxt[r] = lcnt[r] - CNT_W'(1);
        end

        inflight_nxt = inflight;
        if (fire_w && !ret)
            inflight_nxt = inflight + 3'd1;
        else if (!fire_w && ret && inflight != 3'd0)
            inflight_nxt = inflight - 3'd1;

        sb_err_nxt = sb_err ||
                     (ld && lcnt[load_done_rd] == '0) ||
                     (ret && (wcnt[retire_rd] == '0 || inflight == 3'd0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                wcnt[r] <= '0;
                lcnt[r] <= '0;
            end
            inflight <= 3'd0;
            sb_err   <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                wcnt[r] <= wcnt_nxt[r];
                lcnt[r] <= lcnt_nxt[r];
            end
            inflight <= inflight_nxt;
            sb_err   <= sb_err_nxt;
        end
    end
endmodule

// File: tb/tb_ysyx_25020037_hazard_sched.sv
// Directed bench for the hazard scheduler; expected values are hand-computed per step.
module tb_ysyx_25020037_hazard_sched;
    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic       issue_ready;
    logic [3:0] issue_rs1;
    logic       issue_rs1_used;
    logic [3:0] issue_rs2;
    logic       issue_rs2_used;
    logic [3:0] issue_rd;
    logic       issue_we;
    logic       issue_is_load;
    logic       exu_ready;
    logic       flush;
    logic       load_done_valid;
    logic [3:0] load_done_rd;
    logic       retire_valid;
    logic [3:0] retire_rd;
    logic [2:0] inflight_cnt;
    logic       stall_load;
    logic       stall_full;
    logic       sb_err;

    int checks = 0;
    int passed = 0;

    ysyx_25020037_hazard_sched dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs1_used(issue_rs1_used),
        .issue_rs2(issue_rs2), .issue_rs2_used(issue_rs2_used),
        .issue_rd(issue_rd), .issue_we(issue_we), .issue_is_load(issue_is_load),
        .exu_ready(exu_ready), .flush(flush),
        .load_done_valid(load_done_valid), .load_done_rd(load_done_rd),
        .retire_valid(retire_valid), .retire_rd(retire_rd),
        .inflight_cnt(inflight_cnt), .stall_load(stall_load),
        .stall_full(stall_full), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs1_used = 0; issue_rs2 = 0; issue_rs2_used = 0;
        issue_rd = 0; issue_we = 0; issue_is_load = 0; exu_ready = 1; flush = 0;
        load_done_valid = 0; load_done_rd = 0; retire_valid = 0; retire_rd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fire_wr(input logic [3:0] rd, input logic is_load);
        idle();
        issue_valid = 1; issue_we = 1; issue_rd = rd; issue_is_load = is_load;
        tick();
        idle();
    endtask

    task automatic retire(input logic [3:0] rd);
        idle();
        retire_valid = 1; retire_rd = rd;
        tick();
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        issue_valid = 1; issue_we = 1; issue_rd = 4'd2;
        #1;
        chk("rst_inflight", 8'(inflight_cnt), 8'd0);
        chk("rst_ready", 8'(issue_ready), 8'd0);
        chk("rst_stall_load", 8'(stall_load), 8'd0);
        chk("rst_stall_full", 8'(stall_full), 8'd0);
        chk("rst_sb_err", 8'(sb_err), 8'd0);
        tick(); tick();
        idle();
        rst = 0;
        #1;
        chk("post_rst_ready", 8'(issue_ready), 8'd1);

        // reset mid-operation
        fire_wr(4'd1, 0);
        fire_wr(4'd2, 0);
        fire_wr(4'd6, 1);
        chk("mid_inflight3", 8'(inflight_cnt), 8'd3);
        issue_rs1 = 4'd6; issue_rs1_used = 1;
        #1;
        chk("mid_stall_load6", 8'(stall_load), 8'd1);
        idle();
        #1;
        rst = 1;
        #1;
        chk("mid_rst_inflight", 8'(inflight_cnt), 8'd0);
        chk("mid_rst_ready", 8'(issue_ready), 8'd0);
        tick();
        rst = 0;
        issue_rs1 = 4'd6; issue_rs1_used = 1;
        #1;
        chk("mid_rel_ready", 8'(issue_ready), 8'd1);
        chk("mid_lcnt_cleared", 8'(stall_load), 8'd0);
        exu_ready = 0;
        #1;
        chk("mid_exu_not_ready", 8'(issue_ready), 8'd0);
        idle();

        // rd=0 writer changes no state
        fire_wr(4'd0, 0);
        chk("rd0_no_state", 8'(inflight_cnt), 8'd0);

        // load-use
        fire_wr(4'd5, 1);
        chk("lu_inflight", 8'(inflight_cnt), 8'd1);
        issue_valid = 1; issue_rs1 = 4'd5; issue_rs1_used = 1;
        #1;
        chk("lu_stall_load", 8'(stall_load), 8'd1);
        chk("lu_ready0", 8'(issue_ready), 8'd0);
        load_done_valid = 1; load_done_rd = 4'd5;
        tick();
        load_done_valid = 0;
        #1;
        chk("lu_stall_clear", 8'(stall_load), 8'd0);
        chk("lu_ready1", 8'(issue_ready), 8'd1);
        tick();
        chk("lu_nowrite_fire", 8'(inflight_cnt), 8'd1);
        retire(4'd5);
        chk("lu_drain", 8'(inflight_cnt), 8'd0);
        chk("lu_no_err", 8'(sb_err), 8'd0);

        // ALU dependency covered by bypass
        fire_wr(4'd3, 0);
        issue_valid = 1; issue_rs2 = 4'd3; issue_rs2_used = 1; issue_we = 1; issue_rd = 4'd3;
        #1;
        chk("alu_dep_ready", 8'(issue_ready), 8'd1);
        tick();
        chk("alu_inflight2", 8'(inflight_cnt), 8'd2);
        #1;
        chk("alu_wcnt2_not_full", 8'(stall_full), 8'd0);
        tick();
        chk("alu_inflight3", 8'(inflight_cnt), 8'd3);
        #1;
        chk("alu_wcnt3_full", 8'(stall_full), 8'd1);
        chk("alu_wcnt3_ready0", 8'(issue_ready), 8'd0);
        retire(4'd3); retire(4'd3); retire(4'd3);
        chk("alu_drain", 8'(inflight_cnt), 8'd0);

        // window full
        fire_wr(4'd1, 0); fire_wr(4'd2, 0); fire_wr(4'd3, 0); fire_wr(4'd4, 0);
        chk("win_inflight4", 8'(inflight_cnt), 8'd4);
        issue_valid = 1; issue_we = 1; issue_rd = 4'd5;
        #1;
        chk("win_stall_full", 8'(stall_full), 8'd1);
        chk("win_ready0", 8'(issue_ready), 8'd0);
        retire_valid = 1; retire_rd = 4'd1;
        #1;
        chk("win_retire_frees", 8'(issue_ready), 8'd1);
        tick();
        chk("win_stays4", 8'(inflight_cnt), 8'd4);
        retire(4'd2); retire(4'd3); retire(4'd4); retire(4'd5);
        chk("win_drain", 8'(inflight_cnt), 8'd0);

        // counter saturation on rd=7
        fire_wr(4'd7, 0); fire_wr(4'd8, 0); retire(4'd8);
        fire_wr(4'd7, 0); fire_wr(4'd7, 0);
        chk("sat_inflight3", 8'(inflight_cnt), 8'd3);
        issue_valid = 1; issue_we = 1; issue_rd = 4'd7;
        retire_valid = 1; retire_rd = 4'd7;
        #1;
        chk("sat_stall_full", 8'(stall_full), 8'd1);
        chk("sat_retire_no_free", 8'(issue_ready), 8'd0);
        tick();
        retire_valid = 0;
        chk("sat_after_retire", 8'(inflight_cnt), 8'd2);
        #1;
        chk("sat_ready_next", 8'(issue_ready), 8'd1);
        tick();
        chk("sat_fire", 8'(inflight_cnt), 8'd3);
        retire(4'd7); retire(4'd7); retire(4'd7);
        chk("sat_drain", 8'(inflight_cnt), 8'd0);
        chk("sat_no_err", 8'(sb_err), 8'd0);

        // flush blocks issue
        issue_valid = 1; issue_we = 1; issue_rd = 4'd8; flush = 1;
        #1;
        chk("flush_ready0", 8'(issue_ready), 8'd0);
        tick();
        chk("flush_no_state", 8'(inflight_cnt), 8'd0);
        idle();
        issue_we = 1; issue_rd = 4'd8;
        #1;
        chk("novalid_ready1", 8'(issue_ready), 8'd1);
        tick();
        chk("novalid_no_state", 8'(inflight_cnt), 8'd0);
        idle();

        // underflow error is sticky until reset
        retire(4'd9);
        chk("err_set", 8'(sb_err), 8'd1);
        chk("err_inflight_hold", 8'(inflight_cnt), 8'd0);
        tick(); tick();
        chk("err_sticky", 8'(sb_err), 8'd1);
        rst = 1;
        #1;
        chk("err_rst_clear", 8'(sb_err), 8'd0);
        tick();
        rst = 0;
        load_done_valid = 1; load_done_rd = 4'd4;
        tick();
        idle();
        chk("err_load_underflow", 8'(sb_err), 8'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
